// File: rtl/calc_entry_ctrl_pkg.sv
// Shared encodings for the calculator keypad-entry sequencer: key codes,
// operator / display encodings, FSM states and small key-decode helpers.
package calc_entry_ctrl_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_CLR = 4'd14;
  localparam logic [3:0] KEY_EQ  = 4'd15;

  typedef enum logic [1:0] {OPER_ADD, OPER_SUB, OPER_MUL, OPER_DIV} oper_e;
  typedef enum logic [1:0] {DISP_OP1, DISP_OPR, DISP_OP2, DISP_RES} disp_e;
  typedef enum logic [2:0] {ST_OP1, ST_OPR, ST_OP2, ST_WAIT, ST_SHOW} state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } key_t;

  function automatic logic is_digit(logic [3:0] k);
    return k < 4'd10;
  endfunction

  function automatic logic is_oper(logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

  function automatic oper_e key_to_oper(logic [3:0] k);
    logic [3:0] t;
    t = k - KEY_ADD;
    return oper_e'(t[1:0]);
  endfunction

endpackage

// File: rtl/calc_entry_ctrl_if.sv
// Key-strobe / operand bus between keypad comparator, entry sequencer and
// the arithmetic datapath. slave = the sequencer.
interface calc_entry_ctrl_if #(parameter int NUM_W = 10);
  logic             key_valid;
  logic [3:0]       key_code;
  logic             op_done;
  logic [NUM_W-1:0] num1;
  logic [NUM_W-1:0] num2;
  logic             sig1;
  logic [1:0]       oper;
  logic             op_start;
  logic [1:0]       disp_mode;
  logic             err;

  modport master (
    output key_valid, key_code, op_done,
    input  num1, num2, sig1, oper, op_start, disp_mode, err
  );

  modport slave (
    input  key_valid, key_code, op_done,
    output num1, num2, sig1, oper, op_start, disp_mode, err
  );
endinterface

// File: rtl/calc_entry_ctrl_bcd_accum.sv
// Decimal digit accumulator: value = value*10 + d, capped at MAX_DIGITS
// significant digits; leading zeros do not consume a digit slot.
module calc_entry_ctrl_bcd_accum #(
  parameter int MAX_DIGITS = 3,
  parameter int NUM_W      = 10,
  parameter int CNT_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [3:0]       d,
  output logic [NUM_W-1:0] value,
  output logic [CNT_W-1:0] count
);

  logic [NUM_W+3:0] next_val;
  logic [NUM_W-1:0] d_ext;

  assign d_ext    = {{(NUM_W-4){1'b0}}, d};
  assign next_val = ({4'b0, value} << 3) + ({4'b0, value} << 1) + {4'b0, d_ext};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      count <= '0;
    end else if (clr) begin
      value <= '0;
      count <= '0;
    end else if (load) begin
      value <= d_ext;
      count <= (d != 4'd0) ? CNT_W'(1) : '0;
    end else if (en && (count < CNT_W'(MAX_DIGITS))) begin
      value <= next_val[NUM_W-1:0];
      if ((count != '0) || (d != 4'd0))
        count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad-entry sequencer: builds signed operand 1, operator and operand 2,
// launches the arithmetic unit on '=' and times out its done handshake.
module calc_entry_ctrl
  import calc_entry_ctrl_pkg::*;
#(
  parameter int MAX_DIGITS = 3,
  parameter int NUM_W      = 10,
  parameter int TIMEOUT    = 1000
) (
  input logic              clk,
  input logic              rst_n,
  calc_entry_ctrl_if.slave bus
);

  localparam int CNT_W   = $clog2(MAX_DIGITS + 1);
  localparam int TIMER_W = $clog2(TIMEOUT) > 0 ? $clog2(TIMEOUT) : 1;
  localparam int NUM_OPS = 2;

  key_t   key;
  logic   k_digit, k_oper, k_clr, k_eq, k_sub;

  state_e             state;
  logic               sig1_q;
  oper_e              oper_q;
  logic               op_start_q;
  disp_e              disp_q;
  logic               err_q;
  logic [TIMER_W-1:0] timer;

  logic [NUM_OPS-1:0]            acc_clr, acc_load, acc_en;
  logic [NUM_OPS-1:0][NUM_W-1:0] acc_val;
  logic [NUM_OPS-1:0][CNT_W-1:0] acc_cnt;

  assign key     = '{valid: bus.key_valid, code: bus.key_code};
  assign k_digit = key.valid && is_digit(key.code);
  assign k_oper  = key.valid && is_oper(key.code);
  assign k_clr   = key.valid && (key.code == KEY_CLR);
  assign k_eq    = key.valid && (key.code == KEY_EQ);
  assign k_sub   = key.valid && (key.code == KEY_SUB);

  // Operand 0 = num1, operand 1 = num2.
  always_comb begin
    acc_clr  = '0;
    acc_load = '0;
    acc_en   = '0;
    if (k_clr) begin
      acc_clr = '1;
    end else if (k_digit) begin
      case (state)
        ST_OP1:  acc_en[0]   = 1'b1;
        ST_OPR:  acc_load[1] = 1'b1;
        ST_OP2:  acc_en[1]   = 1'b1;
        ST_SHOW: begin
          acc_load[0] = 1'b1;
          acc_clr[1]  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_acc
    calc_entry_ctrl_bcd_accum #(
      .MAX_DIGITS(MAX_DIGITS), .NUM_W(NUM_W), .CNT_W(CNT_W)
    ) u_acc (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (acc_clr[g]),
      .load (acc_load[g]),
      .en   (acc_en[g]),
      .d    (key.code),
      .value(acc_val[g]),
      .count(acc_cnt[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_OP1;
      sig1_q     <= 1'b0;
      oper_q     <= OPER_ADD;
      op_start_q <= 1'b0;
      disp_q     <= DISP_OP1;
      err_q      <= 1'b0;
      timer      <= '0;
    end else begin
      op_start_q <= 1'b0;
      if (k_clr) begin
        state  <= ST_OP1;
        sig1_q <= 1'b0;
        oper_q <= OPER_ADD;
        disp_q <= DISP_OP1;
        err_q  <= 1'b0;
        timer  <= '0;
      end else begin
        case (state)
          ST_OP1: begin
            if (k_sub && (acc_cnt[0] == '0)) begin
              sig1_q <= ~sig1_q;
            end else if (k_oper && (acc_cnt[0] != '0)) begin
              oper_q <= key_to_oper(key.code);
              state  <= ST_OPR;
              disp_q <= DISP_OPR;
            end
          end
          ST_OPR: begin
            if (k_oper) begin
              oper_q <= key_to_oper(key.code);
            end else if (k_digit) begin
              state  <= ST_OP2;
              disp_q <= DISP_OP2;
            end
          end
          ST_OP2: begin
            // Digit count is zero exactly when the accumulated value is zero.
            if (k_eq) begin
              if ((oper_q == OPER_DIV) && (acc_cnt[1] == '0)) begin
                err_q <= 1'b1;
                state <= ST_SHOW;
              end else begin
                op_start_q <= 1'b1;
                timer      <= '0;
                state      <= ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
            // op_done beats a coincident timeout.
            if (bus.op_done) begin
              state  <= ST_SHOW;
              disp_q <= DISP_RES;
            end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
              err_q <= 1'b1;
              state <= ST_SHOW;
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
          ST_SHOW: begin
            if (k_digit) begin
              sig1_q <= 1'b0;
              state  <= ST_OP1;
              disp_q <= DISP_OP1;
            end
          end
          default: state <= ST_OP1;
        endcase
      end
    end
  end

  assign bus.num1      = acc_val[0];
  assign bus.num2      = acc_val[1];
  assign bus.sig1      = sig1_q;
  assign bus.oper      = oper_q;
  assign bus.op_start  = op_start_q;
  assign bus.disp_mode = disp_q;
  assign bus.err       = err_q;

endmodule
